// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled 8E1 deserialiser with ready/overrun handshake.
// Build option UART_RX_MAJORITY_EN selects 2-of-3 majority sampling per bit.
module uart_rx #(
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk16x,
  input  logic       clrn,
  input  logic       rxd,
  input  logic       rdn,
  output logic [7:0] d_out,
  output logic       r_ready,
  output logic       parity_error,
  output logic       frame_error,
  output logic       overrun,
  output logic       receiving,
  output logic [3:0] no_bits_rcvd
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [CNT_W-1:0] START_TICK = CNT_W'(OVERSAMPLE / 2);
`else
  localparam logic [CNT_W-1:0] START_TICK = CNT_W'(OVERSAMPLE / 2 - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                   r_state;
  logic [SYNC_STAGES-1:0]   r_sync;
  logic [CNT_W-1:0]         r_cnt;
  logic [7:0]               r_shift;
  logic                     r_perr;

  state_t                   w_state_nxt;
  logic [CNT_W-1:0]         w_cnt_nxt;
  logic [7:0]               w_shift_nxt;
  logic                     w_perr_nxt;
  logic [7:0]               w_dout_nxt;
  logic                     w_ready_nxt;
  logic                     w_pe_nxt;
  logic                     w_fe_nxt;
  logic                     w_ov_nxt;
  logic                     w_rcv_nxt;
  logic [3:0]               w_nbits_nxt;
  logic                     w_done;
  logic                     w_rxs;
  logic                     w_bit;
  logic [2:0]               w_idx;

  assign w_rxs = r_sync[SYNC_STAGES-1];
  assign w_idx = 3'(no_bits_rcvd - 4'd1);

`ifdef UART_RX_MAJORITY_EN
  // Last two synchronised samples; with the current one they straddle the centre tick.
  logic [1:0] r_hist;

  always_ff @(posedge clk16x) begin
    if (!clrn) r_hist <= 2'b11;
    else       r_hist <= {r_hist[0], w_rxs};
  end

  assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rxs) | (r_hist[0] & w_rxs);
`else
  assign w_bit = w_rxs;
`endif

  always_ff @(posedge clk16x) begin
    if (!clrn) begin
      r_sync       <= '1;
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_perr       <= 1'b0;
      d_out        <= '0;
      r_ready      <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      overrun      <= 1'b0;
      receiving    <= 1'b0;
      no_bits_rcvd <= '0;
    end else begin
      r_sync       <= {r_sync[SYNC_STAGES-2:0], rxd};
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_perr       <= w_perr_nxt;
      d_out        <= w_dout_nxt;
      r_ready      <= w_ready_nxt;
      parity_error <= w_pe_nxt;
      frame_error  <= w_fe_nxt;
      overrun      <= w_ov_nxt;
      receiving    <= w_rcv_nxt;
      no_bits_rcvd <= w_nbits_nxt;
    end
  end

  // Frame sequencing plus the CPU-side handshake; completion takes priority over a read.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = (r_cnt == LAST_TICK) ? '0 : r_cnt + CNT_W'(1);
    w_shift_nxt = r_shift;
    w_perr_nxt  = r_perr;
    w_dout_nxt  = d_out;
    w_ready_nxt = r_ready;
    w_pe_nxt    = parity_error;
    w_fe_nxt    = frame_error;
    w_ov_nxt    = overrun;
    w_rcv_nxt   = receiving;
    w_nbits_nxt = no_bits_rcvd;
    w_done      = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rxs) begin
          w_state_nxt = S_START;
          w_rcv_nxt   = 1'b1;
        end
      end
      S_START: begin
        if (r_cnt == START_TICK) begin
          w_cnt_nxt = '0;
          if (w_bit) begin
            w_state_nxt = S_IDLE;
            w_rcv_nxt   = 1'b0;
          end else begin
            w_state_nxt = S_DATA;
            w_nbits_nxt = 4'd1;
          end
        end
      end
      S_DATA: begin
        if (r_cnt == LAST_TICK) begin
          w_shift_nxt[w_idx] = w_bit;
          w_nbits_nxt        = no_bits_rcvd + 4'd1;
          if (no_bits_rcvd == 4'd8) w_state_nxt = S_PARITY;
        end
      end
      S_PARITY: begin
        if (r_cnt == LAST_TICK) begin
          w_perr_nxt  = w_bit ^ (^r_shift);
          w_state_nxt = S_STOP;
          w_nbits_nxt = 4'd10;
        end
      end
      S_STOP: begin
        // Finish at mid stop bit so a following start edge is not missed.
        if (r_cnt == LAST_TICK) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
          w_rcv_nxt   = 1'b0;
          w_nbits_nxt = 4'd0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_rcv_nxt   = 1'b0;
        w_nbits_nxt = 4'd0;
      end
    endcase

    if (w_done) begin
      w_dout_nxt  = r_shift;
      w_pe_nxt    = r_perr;
      w_fe_nxt    = ~w_bit;
      w_ov_nxt    = overrun | (r_ready & rdn);
      w_ready_nxt = 1'b1;
    end else if (!rdn) begin
      w_ready_nxt = 1'b0;
      w_ov_nxt    = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven bit-serially, expected results queued
// at send time and checked at the completion cycle.
module tb_uart_rx;

  logic       clk16x = 1'b0;
  logic       clrn;
  logic       rxd;
  logic       rdn;
  logic [7:0] d_out;
  logic       r_ready;
  logic       parity_error;
  logic       frame_error;
  logic       overrun;
  logic       receiving;
  logic [3:0] no_bits_rcvd;

  always #5 clk16x = ~clk16x;

  uart_rx dut (
    .clk16x       (clk16x),
    .clrn         (clrn),
    .rxd          (rxd),
    .rdn          (rdn),
    .d_out        (d_out),
    .r_ready      (r_ready),
    .parity_error (parity_error),
    .frame_error  (frame_error),
    .overrun      (overrun),
    .receiving    (receiving),
    .no_bits_rcvd (no_bits_rcvd)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       ov;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic m_ready = 1'b0;
  logic m_ov    = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk16x);
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_d_out"},        d_out,            8'h00);
    chk({pfx, "_r_ready"},      8'(r_ready),      8'h00);
    chk({pfx, "_parity_error"}, 8'(parity_error), 8'h00);
    chk({pfx, "_frame_error"},  8'(frame_error),  8'h00);
    chk({pfx, "_overrun"},      8'(overrun),      8'h00);
    chk({pfx, "_receiving"},    8'(receiving),    8'h00);
    chk({pfx, "_no_bits"},      8'(no_bits_rcvd), 8'h00);
  endtask

  // One-cycle CPU read; model clears ready and overrun.
  task automatic read_pulse();
    @(negedge clk16x) rdn = 1'b0;
    @(negedge clk16x) rdn = 1'b1;
    m_ready = 1'b0;
    m_ov    = 1'b0;
  endtask

  // Drive a full 11-bit frame, 16 clocks per bit. Negedge index n = 16*b + c follows posedge n.
  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                            input logic rd_at_end, input int abort_bit, input logic chk_lat);
    logic [10:0] bits;
    exp_t        e;
    exp_t        got;
    bits = {stop, par, data, 1'b0};
    if (abort_bit < 0) begin
      e.data = data;
      e.pe   = par ^ (^data);
      e.fe   = ~stop;
      e.ov   = m_ov | (m_ready & ~rd_at_end);
      sb_q.push_back(e);
    end
    for (int b = 0; b < 11; b++) begin
      for (int c = 0; c < 16; c++) begin
        @(negedge clk16x);
        rxd = bits[b];
        if (b == abort_bit && c == 8) begin
          chk("mid_frame_no_bits", 8'(no_bits_rcvd), 8'(abort_bit));
          chk("mid_frame_receiving", 8'(receiving), 8'h01);
          clrn = 1'b0;
          rxd  = 1'b1;
          @(negedge clk16x);
          chk_zero("abort_rst");
          clrn    = 1'b1;
          m_ready = 1'b0;
          m_ov    = 1'b0;
          return;
        end
        if (chk_lat && b == 0 && c == 2) chk("start_not_yet", 8'(receiving), 8'h00);
        if (chk_lat && b == 0 && c == 3) chk("start_entry", 8'(receiving), 8'h01);
        if (chk_lat && b == 10 && c == 10) chk("ready_early", 8'(r_ready), 8'h00);
        if (rd_at_end && b == 10 && c == 10) rdn = 1'b0;
        if (b == 10 && c == 11) begin
          if (rd_at_end) rdn = 1'b1;
          chk("sb_pending", 8'(sb_q.size()), 8'h01);
          if (sb_q.size() != 0) begin
            got = sb_q.pop_front();
            chk("done_d_out",        d_out,            got.data);
            chk("done_parity_error", 8'(parity_error), 8'(got.pe));
            chk("done_frame_error",  8'(frame_error),  8'(got.fe));
            chk("done_overrun",      8'(overrun),      8'(got.ov));
            chk("done_r_ready",      8'(r_ready),      8'h01);
            chk("done_receiving",    8'(receiving),    8'h00);
            m_ready = 1'b1;
            m_ov    = got.ov;
          end
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    clrn = 1'b0;
    rxd  = 1'b1;
    rdn  = 1'b1;
    tick(3);
    chk_zero("reset");
    clrn = 1'b1;
    tick(5);

    // Clean byte with exact latency from START entry.
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, -1, 1'b1);
    tick(4);
    read_pulse();
    chk("a5_read_ready", 8'(r_ready), 8'h00);

    // Wrong parity bit; read clears ready but keeps the error flag.
    send_frame(8'h07, 1'b0, 1'b1, 1'b0, -1, 1'b0);
    tick(2);
    read_pulse();
    chk("p07_read_ready", 8'(r_ready), 8'h00);
    chk("p07_pe_held", 8'(parity_error), 8'h01);
    chk("p07_d_out_held", d_out, 8'h07);

    // Stop bit low, then line released: no spurious second frame.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    rxd = 1'b1;
    tick(40);
    chk("fe_idle_receiving", 8'(receiving), 8'h00);
    chk("fe_no_overrun", 8'(overrun), 8'h00);
    chk("fe_ready_held", 8'(r_ready), 8'h01);
    chk("fe_d_out_held", d_out, 8'h3C);
    chk("fe_flag_held", 8'(frame_error), 8'h01);
    read_pulse();

    // Back-to-back without a read sets overrun.
    send_frame(8'h11, 1'b0, 1'b1, 1'b0, -1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0, -1, 1'b0);
    read_pulse();
    chk("ovr_read_clears_ov", 8'(overrun), 8'h00);
    chk("ovr_read_clears_rdy", 8'(r_ready), 8'h00);

    // Read on the exact completion cycle: completion wins, no overrun.
    send_frame(8'h11, 1'b0, 1'b1, 1'b0, -1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b1, -1, 1'b0);
    tick(1);
    chk("rdsim_ready_stays", 8'(r_ready), 8'h01);
    read_pulse();

    // Short low glitch while idle is a false start.
    @(negedge clk16x) rxd = 1'b0;
    tick(3);
    @(negedge clk16x) rxd = 1'b1;
    chk("glitch_receiving_hi", 8'(receiving), 8'h01);
    tick(20);
    chk("glitch_receiving_lo", 8'(receiving), 8'h00);
    chk("glitch_no_ready", 8'(r_ready), 8'h00);
    chk("glitch_no_bits", 8'(no_bits_rcvd), 8'h00);

    // Reset during data bit 5, then a fresh frame.
    send_frame(8'h96, 1'b0, 1'b1, 1'b0, 5, 1'b0);
    tick(10);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, -1, 1'b0);
    tick(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
